// File: rtl/rpn_stack_calc.sv
// rpn_stack_calc: pushbutton-driven RPN calculator with a small operand stack.
// Enter pushes DataIn, Exec applies opcode DataIn[2:0] to the top two entries,
// Clear empties the stack and leaves the ERROR state.
// Optional macro RPN_DEBOUNCE_EN: debounce each button over N_DEBOUNCER samples.
module rpn_stack_calc #(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int N_DEBOUNCER = 10
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         Enter,
  input  logic                         Exec,
  input  logic                         Clear,
  input  logic [WIDTH-1:0]             DataIn,
  output logic [WIDTH-1:0]             ToDisplay,
  output logic [3:0]                   Flags,
  output logic [2:0]                   Status,
  output logic [$clog2(DEPTH+1)-1:0]   Count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || N_DEBOUNCER < 1) begin : g_param_check
    $error("rpn_stack_calc: DEPTH must be >= 2 and N_DEBOUNCER >= 1");
  end

  typedef enum logic [2:0] {
    S_READY = 3'b000,
    S_PUSH  = 3'b001,
    S_EXEC  = 3'b010,
    S_WB    = 3'b011,
    S_ERROR = 3'b100
  } state_t;

  state_t state, state_n;

  // Button conditioning: bit 0 = Enter, bit 1 = Exec, bit 2 = Clear
  logic [2:0] raw, lvl, lvl_q, pulse;
  logic       p_ent, p_exe, p_clr;

  assign raw   = {Clear, Exec, Enter};
  assign pulse = lvl & ~lvl_q;
  assign p_ent = pulse[0];
  assign p_exe = pulse[1];
  assign p_clr = pulse[2];

`ifdef RPN_DEBOUNCE_EN
  localparam int DW = $clog2(N_DEBOUNCER + 1);
  logic [DW-1:0] dcnt [3];

  // Debounce: level follows the raw input after N_DEBOUNCER consecutive differing samples
  always_ff @(posedge clk) begin
    if (!resetN) begin
      lvl   <= '0;
      lvl_q <= '0;
      for (int unsigned i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      lvl_q <= lvl;
      for (int unsigned i = 0; i < 3; i++) begin
        if (raw[i] == lvl[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(N_DEBOUNCER - 1)) begin
          lvl[i]  <= raw[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Single input register per button plus the edge-detect history register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      lvl   <= '0;
      lvl_q <= '0;
    end else begin
      lvl   <= raw;
      lvl_q <= lvl;
    end
  end
`endif

  // Operand stack and datapath registers
  logic [WIDTH-1:0] stk [DEPTH];
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       nf_q, flags_q;
  logic [AW-1:0]    idx_top, idx_below, idx_push;

  assign idx_top   = AW'(cnt - 1'b1);
  assign idx_below = AW'(cnt - 2'd2);
  assign idx_push  = AW'(cnt);

  // ALU on the two top entries: a = below top, b = top
  logic [WIDTH-1:0] a, b, r;
  logic [WIDTH:0]   sum;
  logic             c, v;

  assign a = stk[idx_below];
  assign b = stk[idx_top];

  // Result plus carry/overflow for the latched opcode
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (op_q)
      3'd0: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      default: r = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!resetN) state <= S_READY;
    else         state <= state_n;
  end

  // Next-state logic; Clear overrides everything, Enter beats Exec in READY
  always_comb begin
    state_n = state;
    case (state)
      S_READY: begin
        if (p_ent)      state_n = (cnt < CW'(DEPTH)) ? S_PUSH : S_ERROR;
        else if (p_exe) state_n = (cnt >= CW'(2) && DataIn[2:0] <= 3'd4) ? S_EXEC : S_ERROR;
      end
      S_PUSH:  state_n = S_READY;
      S_EXEC:  state_n = S_WB;
      S_WB:    state_n = S_READY;
      S_ERROR: state_n = S_ERROR;
      default: state_n = S_READY;
    endcase
    if (p_clr) state_n = S_READY;
  end

  // Count, opcode latch, execute results and published flags
  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      nf_q    <= '0;
      flags_q <= '0;
    end else if (p_clr) begin
      cnt <= '0;
    end else begin
      case (state)
        S_READY: if (p_exe && !p_ent) op_q <= DataIn[2:0];
        S_PUSH:  cnt <= cnt + 1'b1;
        S_EXEC: begin
          res_q <= r;
          nf_q  <= {r[WIDTH-1], (r == '0), c, v};
        end
        S_WB: begin
          cnt     <= cnt - 1'b1;
          flags_q <= nf_q;
        end
        default: ;
      endcase
    end
  end

  // Stack storage writes; reset and Clear suppress any pending write
  always_ff @(posedge clk) begin
    if (resetN && !p_clr) begin
      if (state == S_PUSH)    stk[idx_push]  <= DataIn;
      else if (state == S_WB) stk[idx_below] <= res_q;
    end
  end

  assign ToDisplay = (cnt == '0) ? '0 : stk[idx_top];
  assign Flags     = flags_q;
  assign Status    = state;
  assign Count     = cnt;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed self-checking bench for rpn_stack_calc (WIDTH=16, DEPTH=4).
module tb_rpn_stack_calc;

  logic        clk = 1'b0;
  logic        resetN, Enter, Exec, Clear;
  logic [15:0] DataIn;
  logic [15:0] ToDisplay;
  logic [3:0]  Flags;
  logic [2:0]  Status;
  logic [2:0]  Count;

  int total = 0;
  int bad   = 0;

  rpn_stack_calc #(.WIDTH(16), .DEPTH(4), .N_DEBOUNCER(10)) dut (
    .clk(clk), .resetN(resetN), .Enter(Enter), .Exec(Exec), .Clear(Clear),
    .DataIn(DataIn), .ToDisplay(ToDisplay), .Flags(Flags), .Status(Status),
    .Count(Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle button press; returns at the negedge where the internal pulse is live
  task automatic press(input logic e, input logic x, input logic c, input logic [15:0] d);
    @(negedge clk);
    Enter = e; Exec = x; Clear = c; DataIn = d;
    @(negedge clk);
    Enter = 1'b0; Exec = 1'b0; Clear = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    press(1'b1, 1'b0, 1'b0, v);
    repeat (2) @(negedge clk);
  endtask

  task automatic exec_op(input logic [2:0] op);
    press(1'b0, 1'b1, 1'b0, {13'd0, op});
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_all();
    press(1'b0, 1'b0, 1'b1, 16'h0000);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    resetN = 1'b0; Enter = 1'b0; Exec = 1'b0; Clear = 1'b0; DataIn = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", Count, 0);
    chk("rst_disp", ToDisplay, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_status", Status, 0);
    resetN = 1'b1;

    // 3 + 5 with latency/state observation
    press(1'b1, 1'b0, 1'b0, 16'h0003);
    @(negedge clk);
    chk("push_state", Status, 3'b001);
    chk("push_disp_old", ToDisplay, 16'h0000);
    @(negedge clk);
    chk("push_disp_new", ToDisplay, 16'h0003);
    chk("push_count", Count, 1);
    chk("push_ready", Status, 3'b000);
    push(16'h0005);
    chk("push2_disp", ToDisplay, 16'h0005);
    chk("push2_count", Count, 2);
    press(1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    chk("exec_state", Status, 3'b010);
    @(negedge clk);
    chk("wb_state", Status, 3'b011);
    chk("wb_disp_old", ToDisplay, 16'h0005);
    @(negedge clk);
    chk("add_disp", ToDisplay, 16'h0008);
    chk("add_count", Count, 1);
    chk("add_flags", Flags, 4'b0000);
    clear_all();

    // 2 - 5
    push(16'h0002); push(16'h0005); exec_op(3'd1);
    chk("sub_disp", ToDisplay, 16'hFFFD);
    chk("sub_flags", Flags, 4'b1010);
    clear_all();
    chk("clr_count", Count, 0);
    chk("clr_disp", ToDisplay, 0);
    chk("clr_flags_kept", Flags, 4'b1010);
    chk("clr_status", Status, 0);

    // 0x7FFF + 1 overflow
    push(16'h7FFF); push(16'h0001); exec_op(3'd0);
    chk("ovf_disp", ToDisplay, 16'h8000);
    chk("ovf_flags", Flags, 4'b1001);
    clear_all();

    // logic ops chained
    push(16'hF0F0); push(16'hFF00); exec_op(3'd2);
    chk("and_disp", ToDisplay, 16'hF000);
    chk("and_flags", Flags, 4'b1000);
    push(16'h0F0F); exec_op(3'd3);
    chk("or_disp", ToDisplay, 16'hFF0F);
    push(16'hFF0F); exec_op(3'd4);
    chk("xor_disp", ToDisplay, 16'h0000);
    chk("xor_flags", Flags, 4'b0100);
    chk("xor_count", Count, 1);
    clear_all();

    // Exec with one entry
    push(16'h0011); exec_op(3'd0);
    chk("err1_status", Status, 3'b100);
    chk("err1_count", Count, 1);
    chk("err1_disp", ToDisplay, 16'h0011);
    push(16'h0022);
    chk("err1_enter_ign", Count, 1);
    chk("err1_flags", Flags, 4'b0100);
    clear_all();
    // invalid opcode
    push(16'h0001); push(16'h0002); exec_op(3'd6);
    chk("err2_status", Status, 3'b100);
    chk("err2_count", Count, 2);
    chk("err2_disp", ToDisplay, 16'h0002);
    clear_all();

    // overflow the stack
    for (int i = 1; i <= 4; i++) push(16'(i));
    chk("full_count", Count, 4);
    chk("full_status", Status, 0);
    push(16'h0005);
    chk("ovr_status", Status, 3'b100);
    chk("ovr_count", Count, 4);
    chk("ovr_disp", ToDisplay, 16'h0004);
    push(16'h0006);
    chk("ovr_enter_ign", Count, 4);
    clear_all();
    chk("ovr_clr_status", Status, 0);
    chk("ovr_clr_count", Count, 0);

    // Enter and Exec together: push only
    press(1'b1, 1'b1, 1'b0, 16'h0009);
    repeat (5) @(negedge clk);
    chk("both_count", Count, 1);
    chk("both_disp", ToDisplay, 16'h0009);
    chk("both_status", Status, 0);

    // reset during WB
    push(16'h0006);
    press(1'b0, 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wb", Status, 3'b011);
    resetN = 1'b0;
    @(negedge clk);
    chk("abort_count", Count, 0);
    chk("abort_disp", ToDisplay, 0);
    chk("abort_flags", Flags, 0);
    chk("abort_status", Status, 0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rpn_stack_calc.md
RPN_STACK_CALC -- requirements
Module: rpn_stack_calc

Interface
REQ-001 Parameter WIDTH, default 16, sets the data, operand and result width in bits.
REQ-002 Parameter DEPTH, default 4, sets the operand stack depth; DEPTH SHALL be at least 2.
REQ-003 Parameter N_DEBOUNCER, default 10, sets the debounce stable-cycle count; it SHALL be used only when RPN_DEBOUNCE_EN is defined.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port resetN, input, 1 bit: the reset; it SHALL be synchronous and active-low.
REQ-006 Port Enter, input, 1 bit: pushbutton; pushes DataIn onto the stack.
REQ-007 Port Exec, input, 1 bit: pushbutton; executes opcode DataIn[2:0] on the top two stack entries.
REQ-008 Port Clear, input, 1 bit: pushbutton; empties the stack and clears the error condition.
REQ-009 Port DataIn, input, WIDTH bits: the operand on push, and the opcode in bits [2:0] on execute.
REQ-010 Port ToDisplay, output, WIDTH bits: the top-of-stack value, or 0 when the stack is empty.
REQ-011 Port Flags, output, 4 bits: {N,Z,C,V} of the last successful execute.
REQ-012 Port Status, output, 3 bits: the FSM state code.
REQ-013 Port Count, output, $clog2(DEPTH+1) bits: the number of valid stack entries.

Function
REQ-014 Each button SHALL produce a one-cycle internal pulse per press, as conditioned per REQ-034/REQ-035.
REQ-015 The FSM states and Status codes SHALL be READY=000, PUSH=001, EXEC=010, WB=011, ERROR=100.
REQ-016 A Clear pulse in any state SHALL, at the next edge: set Count=0, go to READY, and leave Flags unchanged.
REQ-017 In READY, Clear SHALL have priority over Enter, and Enter over Exec; a lower-priority pulse in the same cycle SHALL be dropped.
REQ-018 On an Enter pulse in READY: if Count<DEPTH, go to PUSH; otherwise go to ERROR with the stack unchanged.
REQ-019 In PUSH, DataIn SHALL be written above the top, Count incremented, and the FSM returned to READY, all in 1 cycle.
REQ-020 On an Exec pulse in READY: if Count>=2 and opcode<=4, go to EXEC; otherwise go to ERROR with the stack unchanged.
REQ-021 In EXEC, the FSM SHALL register A=entry below top, B=top, the result and the flags, then go to WB.
REQ-022 In WB, the FSM SHALL pop both operands, push the result, decrement Count by 1, update Flags, and return to READY.
REQ-023 Opcodes SHALL be: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B; 101-111 are invalid.
REQ-024 All arithmetic SHALL be modulo 2^WIDTH.
REQ-025 N SHALL equal result[WIDTH-1], and Z SHALL be 1 exactly when result==0.
REQ-026 C SHALL be the carry-out for ADD, 1 when A<B unsigned for SUB, and 0 for logic ops.
REQ-027 V SHALL be the two's-complement overflow for ADD/SUB and 0 for logic ops.
REQ-028 ERROR SHALL hold with the stack and Flags frozen until a Clear pulse; Enter/Exec pulses in ERROR SHALL be ignored.
REQ-029 Pulses arriving in PUSH, EXEC or WB SHALL be dropped, except Clear.
REQ-030 ToDisplay SHALL reflect the new top from the cycle after the PUSH/WB edge.
REQ-031 Latency from an accepted pulse to the updated ToDisplay SHALL be 2 cycles for push and 3 cycles for execute.

Reset
REQ-032 While resetN=0 at an edge: Count=0, ToDisplay=0, Flags=0000, Status=000 (READY), and the debounce/edge registers cleared.
REQ-033 Reset mid-operation (in PUSH, EXEC or WB) SHALL abandon the operation with no partial stack write.

Configuration
REQ-034 With RPN_DEBOUNCE_EN defined, each button level SHALL change only after N_DEBOUNCER consecutive equal samples, and the pulse SHALL be issued on the debounced rising edge.
REQ-035 Without RPN_DEBOUNCE_EN, each button SHALL pass through a single register, and the pulse SHALL be issued on the raw rising edge 1 cycle later.

Verification (WIDTH=16, DEPTH=4, macro undefined)
REQ-036 Push 0x0003, push 0x0005, Exec op 000 -> ToDisplay=0x0008, Count=1, Flags=0000.
REQ-037 Push 0x0002, push 0x0005, Exec op 001 -> ToDisplay=0xFFFD, Flags N=1 Z=0 C=1 V=0.
REQ-038 Push 0x7FFF, push 0x0001, Exec op 000 -> ToDisplay=0x8000, Flags=1001.
REQ-039 Push 5 values -> 5th push causes Status=100 and Count=4; Enter ignored; Clear -> Status=000 and Count=0.
REQ-040 Count=1, Exec -> ERROR; Count=2 with opcode 110 -> ERROR; stack unchanged in both cases.
REQ-041 Enter and Exec pulsed in the same cycle in READY -> only the push occurs; resetN=0 during WB -> all outputs at reset values.
